// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multi-cycle RV32I control FSM.
//   state_t      - FSM states
//   OPC_*        - supported major opcodes (instr[6:0])
//   pc_sel_t, alu_a_sel_t, alu_op_t, wb_sel_t - datapath select encodings
//   opcode_supported() - true for opcodes this core executes
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_sel_t;

    typedef enum logic [1:0] {
        A_RS1  = 2'b00,
        A_PC   = 2'b01,
        A_ZERO = 2'b10
    } alu_a_sel_t;

    localparam logic B_RS2 = 1'b0;
    localparam logic B_IMM = 1'b1;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_t;

    function automatic logic opcode_supported(input logic [6:0] opc);
        logic ok;
        case (opc)
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI,
            OPC_JAL, OPC_OP, OPC_OPIMM: ok = 1'b1;
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// ctrl_watchdog: counts cycles a memory request waits for its ack.
//   clk, rst  - clock, async active-high reset
//   active    - a request is being held (FETCH or MEM)
//   ack       - the ack matching the held request
//   expired   - this is the STALL_LIMIT-th waiting cycle and no ack came
// The count returns to zero whenever no request is waiting or an ack lands,
// so every FETCH/MEM visit starts from zero. STALL_LIMIT = 0 disables expiry.
module ctrl_watchdog #(
    parameter int STALL_LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(STALL_LIMIT - 1);

    logic [CW-1:0] count;

    // Wait counter: clears when idle or acked, saturates at the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {CW{1'b0}};
        end else if (!active || ack) begin
            count <= {CW{1'b0}};
        end else if (count != LAST) begin
            count <= count + CW'(1);
        end else begin
            count <= count;
        end
    end

    // Expiry: the final allowed waiting cycle ends without an ack (ack wins).
    always_comb begin
        if (STALL_LIMIT != 0) begin
            expired = active && !ack && (count == LAST);
        end else begin
            expired = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the RV32I subset.
//   clk, rst                 - clock, async active-high reset
//   ir_opcode, branch_taken  - instruction opcode and comparator result
//   imem_req/imem_ack        - instruction fetch handshake
//   dmem_req/dmem_we/dmem_ack- data access handshake
//   ir_we, pc_we, pc_sel     - IR/PC load controls
//   alu_a_sel, alu_b_sel, alu_op - ALU operand/operation selects
//   reg_we, wb_sel           - register file write controls
//   retired                  - retired-instruction count (wraps)
//   illegal, bus_err         - sticky trap causes
// Outputs decode combinationally from state/opcode and are forced low while
// rst is asserted, so requests drop and enables stay low asynchronously.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int STALL_LIMIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           ir_opcode,
    input  logic                 branch_taken,
    output logic                 imem_req,
    input  logic                 imem_ack,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic [1:0]           alu_a_sel,
    output logic                 alu_b_sel,
    output logic [1:0]           alu_op,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic [CNT_WIDTH-1:0] retired,
    output logic                 illegal,
    output logic                 bus_err
);

    state_t state;
    state_t next_state;

    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic supported;
    logic wd_active;
    logic wd_ack;
    logic wd_expired;
    logic retire;

    assign is_load   = (ir_opcode == OPC_LOAD);
    assign is_store  = (ir_opcode == OPC_STORE);
    assign is_branch = (ir_opcode == OPC_BRANCH);
    assign is_jal    = (ir_opcode == OPC_JAL);
    assign supported = opcode_supported(ir_opcode);

    assign wd_active = (state == S_FETCH) || (state == S_MEM);
    assign wd_ack    = (state == S_FETCH) ? imem_ack : dmem_ack;

    ctrl_watchdog #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .active  (wd_active),
        .ack     (wd_ack),
        .expired (wd_expired)
    );

    // Retiring edges: branch in EXEC, store on its MEM ack, any WB.
    always_comb begin
        if ((state == S_EXEC) && is_branch) begin
            retire = 1'b1;
        end else if ((state == S_MEM) && is_store && dmem_ack) begin
            retire = 1'b1;
        end else if (state == S_WB) begin
            retire = 1'b1;
        end else begin
            retire = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (imem_ack) begin
                    next_state = S_DECODE;
                end else if (wd_expired) begin
                    next_state = S_TRAP;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                if (supported) begin
                    next_state = S_EXEC;
                end else begin
                    next_state = S_TRAP;
                end
            end
            S_EXEC: begin
                case (ir_opcode)
                    OPC_BRANCH:                               next_state = S_FETCH;
                    OPC_LOAD, OPC_STORE:                      next_state = S_MEM;
                    OPC_OP, OPC_OPIMM, OPC_LUI, OPC_JAL:      next_state = S_WB;
                    default:                                  next_state = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (is_store) begin
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end else if (wd_expired) begin
                    next_state = S_TRAP;
                end else begin
                    next_state = S_MEM;
                end
            end
            S_WB:    next_state = S_FETCH;
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_TRAP;
        endcase
    end

    // Output decode from state and opcode; all low while reset is asserted.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_a_sel = A_RS1;
        alu_b_sel = B_RS2;
        alu_op    = ALU_ADD;
        reg_we    = 1'b0;
        wb_sel    = WB_ALU;
        if (rst) begin
            imem_req = 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we = 1'b1;
                    end else begin
                        ir_we = 1'b0;
                    end
                end
                S_EXEC: begin
                    case (ir_opcode)
                        OPC_OP: begin
                            alu_a_sel = A_RS1;
                            alu_b_sel = B_RS2;
                            alu_op    = ALU_FUNCT;
                        end
                        OPC_OPIMM: begin
                            alu_a_sel = A_RS1;
                            alu_b_sel = B_IMM;
                            alu_op    = ALU_FUNCT;
                        end
                        OPC_LUI: begin
                            alu_a_sel = A_ZERO;
                            alu_b_sel = B_IMM;
                            alu_op    = ALU_ADD;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            alu_a_sel = A_RS1;
                            alu_b_sel = B_IMM;
                            alu_op    = ALU_ADD;
                        end
                        OPC_BRANCH: begin
                            alu_a_sel = A_RS1;
                            alu_b_sel = B_RS2;
                            alu_op    = ALU_SUB;
                            pc_we     = 1'b1;
                            if (branch_taken) begin
                                pc_sel = PC_BRANCH;
                            end else begin
                                pc_sel = PC_PLUS4;
                            end
                        end
                        OPC_JAL: begin
                            alu_a_sel = A_PC;
                            alu_b_sel = B_IMM;
                            alu_op    = ALU_ADD;
                        end
                        default: begin
                            alu_op = ALU_ADD;
                        end
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    // A store finishes here, so it advances the PC on its ack.
                    if (is_store && dmem_ack) begin
                        pc_we = 1'b1;
                    end else begin
                        pc_we = 1'b0;
                    end
                end
                S_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    if (is_load) begin
                        wb_sel = WB_MEM;
                    end else if (is_jal) begin
                        wb_sel = WB_PC4;
                    end else begin
                        wb_sel = WB_ALU;
                    end
                    if (is_jal) begin
                        pc_sel = PC_JUMP;
                    end else begin
                        pc_sel = PC_PLUS4;
                    end
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    // Status: retired counter and sticky trap causes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= {CNT_WIDTH{1'b0}};
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (retire) begin
                retired <= retired + CNT_WIDTH'(1);
            end else begin
                retired <= retired;
            end
            if ((state == S_DECODE) && !supported) begin
                illegal <= 1'b1;
            end else begin
                illegal <= illegal;
            end
            if (wd_expired) begin
                bus_err <= 1'b1;
            end else begin
                bus_err <= bus_err;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector bench for multicycle_ctrl
// (CNT_WIDTH=4, STALL_LIMIT=4). Control outputs are packed into one
// 15-bit word {imem_req,dmem_req,dmem_we,ir_we,pc_we,pc_sel,alu_a_sel,
// alu_b_sel,alu_op,reg_we,wb_sel} and compared against hand-built words.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] ir_opcode;
    logic       branch_taken;
    logic       imem_req, imem_ack;
    logic       dmem_req, dmem_we, dmem_ack;
    logic       ir_we, pc_we, alu_b_sel, reg_we;
    logic [1:0] pc_sel, alu_a_sel, alu_op, wb_sel;
    logic [3:0] retired;
    logic       illegal, bus_err;
    logic [14:0] ctl;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] BAD    = 7'b1111111;

    //                          imem  dmem  we    irwe  pcwe  pcsel  asel   bsel  aluop  regwe wbsel
    localparam logic [14:0] C_Z     = 15'd0;
    localparam logic [14:0] C_F     = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    localparam logic [14:0] C_FA    = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    localparam logic [14:0] C_E_OPI = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 2'b00};
    localparam logic [14:0] C_W_ALU = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00};
    localparam logic [14:0] C_E_MEM = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};
    localparam logic [14:0] C_M_LD  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    localparam logic [14:0] C_W_LD  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 2'b01};
    localparam logic [14:0] C_E_BT  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00};
    localparam logic [14:0] C_E_BN  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00};
    localparam logic [14:0] C_E_JAL = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 2'b00, 1'b0, 2'b00};
    localparam logic [14:0] C_W_JAL = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 2'b10};
    localparam logic [14:0] C_M_ST  = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    localparam logic [14:0] C_M_STA = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};

    assign ctl = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
                  alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel};

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .CNT_WIDTH   (4),
        .STALL_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ir_opcode    (ir_opcode),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .alu_op       (alu_op),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .retired      (retired),
        .illegal      (illegal),
        .bus_err      (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered at posedge+1 with inputs set: check this cycle, advance one cycle.
    task automatic cycle(input string tag, input logic [14:0] exp);
        #1;
        chk(tag, {17'd0, ctl}, {17'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [6:0] opc);
        ir_opcode = opc;
        imem_ack  = 1'b1;
        cycle("fetch_ack", C_FA);
        imem_ack  = 1'b0;
    endtask

    task automatic chk_ret(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, retired}, {28'd0, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ctl", {17'd0, ctl}, 32'd0);
        chk("rst_flags", {28'd0, retired, illegal, bus_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ir_opcode = OPIMM; branch_taken = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        chk("reset_ctl", {17'd0, ctl}, 32'd0);
        chk("reset_flags", {28'd0, retired, illegal, bus_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // ADDI, zero-wait: F D E W
        fetch(OPIMM);
        cycle("addi_dec", C_Z);
        cycle("addi_exec", C_E_OPI);
        chk_ret("addi_ret0", 4'd0);
        cycle("addi_wb", C_W_ALU);
        chk_ret("addi_ret1", 4'd1);

        // LW with dmem_ack after 3 waiting cycles: 8 cycles total
        fetch(LOAD);
        cycle("lw_dec", C_Z);
        cycle("lw_exec", C_E_MEM);
        repeat (3) cycle("lw_mem_wait", C_M_LD);
        dmem_ack = 1'b1;
        cycle("lw_mem_ack", C_M_LD);
        dmem_ack = 1'b0;
        cycle("lw_wb", C_W_LD);
        chk_ret("lw_ret", 4'd2);
        chk("lw_no_buserr", {31'd0, bus_err}, 32'd0);

        // BEQ taken, then not taken
        branch_taken = 1'b1;
        fetch(BRANCH);
        cycle("beq_t_dec", C_Z);
        cycle("beq_t_exec", C_E_BT);
        cycle("beq_t_next_fetch", C_F);
        chk_ret("beq_t_ret", 4'd3);
        branch_taken = 1'b0;
        fetch(BRANCH);
        cycle("beq_n_dec", C_Z);
        cycle("beq_n_exec", C_E_BN);
        chk_ret("beq_n_ret", 4'd4);

        // JAL
        fetch(JAL);
        cycle("jal_dec", C_Z);
        cycle("jal_exec", C_E_JAL);
        cycle("jal_wb", C_W_JAL);
        chk_ret("jal_ret", 4'd5);

        // SW with one wait cycle
        fetch(STORE);
        cycle("sw_dec", C_Z);
        cycle("sw_exec", C_E_MEM);
        cycle("sw_mem_wait", C_M_ST);
        dmem_ack = 1'b1;
        cycle("sw_mem_ack", C_M_STA);
        dmem_ack = 1'b0;
        chk_ret("sw_ret", 4'd6);

        // Counter wrap: 10 more branches -> 16 retired -> 0
        for (int i = 0; i < 10; i++) begin
            if (i == 9) chk_ret("wrap_ret15", 4'd15);
            fetch(BRANCH);
            cycle("wrap_dec", C_Z);
            cycle("wrap_exec", C_E_BN);
        end
        chk_ret("wrap_ret0", 4'd0);

        // Fetch ack on exactly the 4th waiting cycle: ack wins
        ir_opcode = OPIMM;
        repeat (3) cycle("late_ack_wait", C_F);
        fetch(OPIMM);
        chk("late_ack_no_buserr", {31'd0, bus_err}, 32'd0);
        cycle("late_ack_dec", C_Z);
        cycle("late_ack_exec", C_E_OPI);
        cycle("late_ack_wb", C_W_ALU);
        chk_ret("late_ack_ret", 4'd1);

        // Reset asserted mid-MEM: request drops without a clock edge
        fetch(LOAD);
        cycle("rmem_dec", C_Z);
        cycle("rmem_exec", C_E_MEM);
        cycle("rmem_mem", C_M_LD);
        #1;
        chk("rmem_req_before", {17'd0, ctl}, {17'd0, C_M_LD});
        rst = 1'b1;
        #1;
        chk("rmem_req_dropped", {17'd0, ctl}, 32'd0);
        chk_ret("rmem_ret_cleared", 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rmem_fetch_after", {17'd0, ctl}, {17'd0, C_F});
        @(posedge clk);
        #1;

        // Illegal opcode: trap after DECODE, no more fetches
        fetch(BAD);
        chk("ill_before", {31'd0, illegal}, 32'd0);
        cycle("ill_dec", C_Z);
        chk("ill_set", {31'd0, illegal}, 32'd1);
        imem_ack = 1'b1;
        cycle("ill_trap1", C_Z);
        cycle("ill_trap2", C_Z);
        imem_ack = 1'b0;
        chk_ret("ill_ret_frozen", 4'd0);
        do_reset();

        // Fetch timeout: 4 cycles without imem_ack -> bus_err
        repeat (3) cycle("fto_wait", C_F);
        chk("fto_not_yet", {31'd0, bus_err}, 32'd0);
        cycle("fto_last", C_F);
        chk("fto_buserr", {31'd0, bus_err}, 32'd1);
        cycle("fto_trap", C_Z);
        do_reset();

        // Data timeout: store waits 4 cycles -> bus_err, nothing retired
        fetch(STORE);
        cycle("dto_dec", C_Z);
        cycle("dto_exec", C_E_MEM);
        repeat (4) cycle("dto_wait", C_M_ST);
        chk("dto_buserr", {31'd0, bus_err}, 32'd1);
        cycle("dto_trap", C_Z);
        chk_ret("dto_ret", 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
